// File: rtl/cprv_mem_arbiter.sv
// cprv_mem_arbiter: arbitrates the fetch (if) and mem-stage (dm) requesters
// onto one memory port through a registered request slot, and routes in-order
// memory responses back using an ID FIFO of outstanding requests.
// Optional: define CPRV_MEM_ARB_RR_EN for round-robin arbitration; otherwise
// dm has fixed priority over if.
module cprv_mem_arbiter #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_if_req_i,
  output logic                  ready_if_req_o,
  input  logic [DATA_WIDTH-1:0] addr_if_req_i,
  output logic                  valid_if_rsp_o,
  input  logic                  ready_if_rsp_i,
  output logic [DATA_WIDTH-1:0] rdata_if_rsp_o,
  input  logic                  valid_dm_req_i,
  output logic                  ready_dm_req_o,
  input  logic [DATA_WIDTH-1:0] addr_dm_req_i,
  input  logic [DATA_WIDTH-1:0] wdata_dm_req_i,
  input  logic                  w_en_dm_req_i,
  output logic                  valid_dm_rsp_o,
  input  logic                  ready_dm_rsp_i,
  output logic [DATA_WIDTH-1:0] rdata_dm_rsp_o,
  output logic                  valid_mem_o,
  input  logic                  ready_mem_i,
  output logic [DATA_WIDTH-1:0] addr_mem_o,
  output logic [DATA_WIDTH-1:0] wdata_mem_o,
  output logic                  w_en_mem_o,
  input  logic                  valid_mem_rsp_i,
  output logic                  ready_mem_rsp_o,
  input  logic [DATA_WIDTH-1:0] rdata_mem_i,
  output logic                  err_o
);

  localparam int unsigned PTR_W = $clog2(OUTSTANDING);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } req_e;

  logic                  valid_mem_q, valid_mem_d;
  logic [DATA_WIDTH-1:0] addr_mem_q, addr_mem_d;
  logic [DATA_WIDTH-1:0] wdata_mem_q, wdata_mem_d;
  logic                  w_en_mem_q, w_en_mem_d;
  logic [PTR_W-1:0]      rptr_q, rptr_d;
  logic [PTR_W-1:0]      wptr_q, wptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;
  req_e                  id_q [OUTSTANDING];

  req_e grant;
  req_e head;
  logic slot_free, can_grant, grant_fire, cnt_nz, push, pop;

  assign slot_free  = ~valid_mem_q | ready_mem_i;
  assign can_grant  = slot_free & (cnt_q != CNT_W'(OUTSTANDING));
  assign grant_fire = can_grant & ((grant == REQ_DM) ? valid_dm_req_i : valid_if_req_i);
  assign cnt_nz     = (cnt_q != '0);
  assign head       = id_q[rptr_q];
  assign push       = grant_fire;
  assign pop        = valid_mem_rsp_i & ready_mem_rsp_o;

`ifdef CPRV_MEM_ARB_RR_EN
  req_e last_q, last_d;

  // Round robin: on contention pick the requester not granted last
  always_comb begin
    grant  = REQ_DM;
    last_d = last_q;
    if (valid_dm_req_i && valid_if_req_i) begin
      grant = (last_q == REQ_IF) ? REQ_DM : REQ_IF;
    end else if (valid_if_req_i) begin
      grant = REQ_IF;
    end
    if (grant_fire) begin
      last_d = grant;
    end
  end

  // Last-grant register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= REQ_IF;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed priority: the mem stage holds the older instruction, so dm wins
  always_comb begin
    grant = (valid_dm_req_i || !valid_if_req_i) ? REQ_DM : REQ_IF;
  end
`endif

  // Request slot: load on grant, hold while stalled, empty when drained
  always_comb begin
    valid_mem_d = valid_mem_q;
    addr_mem_d  = addr_mem_q;
    wdata_mem_d = wdata_mem_q;
    w_en_mem_d  = w_en_mem_q;
    if (grant_fire) begin
      valid_mem_d = 1'b1;
      if (grant == REQ_DM) begin
        addr_mem_d  = addr_dm_req_i;
        wdata_mem_d = wdata_dm_req_i;
        w_en_mem_d  = w_en_dm_req_i;
      end else begin
        addr_mem_d  = addr_if_req_i;
        wdata_mem_d = '0;
        w_en_mem_d  = 1'b0;
      end
    end else if (ready_mem_i) begin
      valid_mem_d = 1'b0;
    end
  end

  // ID FIFO pointers/count and sticky error next state
  always_comb begin
    wptr_d = wptr_q + PTR_W'(push);
    rptr_d = rptr_q + PTR_W'(pop);
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    err_d = err_q | (valid_mem_rsp_i & ~cnt_nz);
  end

  // Control and slot registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_mem_q <= 1'b0;
      addr_mem_q  <= '0;
      wdata_mem_q <= '0;
      w_en_mem_q  <= 1'b0;
      rptr_q      <= '0;
      wptr_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      valid_mem_q <= valid_mem_d;
      addr_mem_q  <= addr_mem_d;
      wdata_mem_q <= wdata_mem_d;
      w_en_mem_q  <= w_en_mem_d;
      rptr_q      <= rptr_d;
      wptr_q      <= wptr_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  // ID storage needs no reset: entries are only read while count != 0
  always_ff @(posedge clk) begin
    if (push) begin
      id_q[wptr_q] <= grant;
    end
  end

  assign ready_if_req_o  = can_grant & (grant == REQ_IF);
  assign ready_dm_req_o  = can_grant & (grant == REQ_DM);

  assign valid_if_rsp_o  = valid_mem_rsp_i & cnt_nz & (head == REQ_IF);
  assign valid_dm_rsp_o  = valid_mem_rsp_i & cnt_nz & (head == REQ_DM);
  assign rdata_if_rsp_o  = rdata_mem_i;
  assign rdata_dm_rsp_o  = rdata_mem_i;
  assign ready_mem_rsp_o = cnt_nz & ((head == REQ_DM) ? ready_dm_rsp_i : ready_if_rsp_i);

  assign valid_mem_o = valid_mem_q;
  assign addr_mem_o  = addr_mem_q;
  assign wdata_mem_o = wdata_mem_q;
  assign w_en_mem_o  = w_en_mem_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_cprv_mem_arbiter.sv
// Scoreboard bench for cprv_mem_arbiter: request drivers and a memory model
// run as independent processes; a monitor pops expected grants, memory
// requests and routed responses as the DUT presents them.
module tb_cprv_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_if_req_i, ready_if_req_o;
  logic [63:0] addr_if_req_i;
  logic        valid_if_rsp_o, ready_if_rsp_i;
  logic [63:0] rdata_if_rsp_o;
  logic        valid_dm_req_i, ready_dm_req_o;
  logic [63:0] addr_dm_req_i, wdata_dm_req_i;
  logic        w_en_dm_req_i;
  logic        valid_dm_rsp_o, ready_dm_rsp_i;
  logic [63:0] rdata_dm_rsp_o;
  logic        valid_mem_o, ready_mem_i;
  logic [63:0] addr_mem_o, wdata_mem_o;
  logic        w_en_mem_o;
  logic        valid_mem_rsp_i, ready_mem_rsp_o;
  logic [63:0] rdata_mem_i;
  logic        err_o;

  always #5 clk = ~clk;

  cprv_mem_arbiter #(.DATA_WIDTH(64), .OUTSTANDING(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_if_req_i(valid_if_req_i), .ready_if_req_o(ready_if_req_o), .addr_if_req_i(addr_if_req_i),
    .valid_if_rsp_o(valid_if_rsp_o), .ready_if_rsp_i(ready_if_rsp_i), .rdata_if_rsp_o(rdata_if_rsp_o),
    .valid_dm_req_i(valid_dm_req_i), .ready_dm_req_o(ready_dm_req_o), .addr_dm_req_i(addr_dm_req_i),
    .wdata_dm_req_i(wdata_dm_req_i), .w_en_dm_req_i(w_en_dm_req_i),
    .valid_dm_rsp_o(valid_dm_rsp_o), .ready_dm_rsp_i(ready_dm_rsp_i), .rdata_dm_rsp_o(rdata_dm_rsp_o),
    .valid_mem_o(valid_mem_o), .ready_mem_i(ready_mem_i), .addr_mem_o(addr_mem_o),
    .wdata_mem_o(wdata_mem_o), .w_en_mem_o(w_en_mem_o),
    .valid_mem_rsp_i(valid_mem_rsp_i), .ready_mem_rsp_o(ready_mem_rsp_o), .rdata_mem_i(rdata_mem_i),
    .err_o(err_o)
  );

  typedef struct { logic [63:0] addr; logic [63:0] wdata; logic wen; } mreq_t;
  typedef struct { logic who; logic [63:0] data; } rsp_t;   // who: 0 = if, 1 = dm
  typedef struct { logic [63:0] data; int due; } pend_t;

  int tests = 0;
  int fails = 0;

  mreq_t if_q[$], dm_q[$], exp_mreq[$];
  logic  exp_grant[$];
  rsp_t  exp_rsp[$];
  pend_t pend[$];
  logic [63:0] mem [logic [63:0]];

  bit mem_rdy = 1'b1;
  bit spurious = 1'b0;
  int rsp_budget = 1000000;
  int n_grant = 0;
  int cyc = 0;
  bit if_hs = 1'b0, dm_hs = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit tb_idle();
    return (if_q.size() == 0) && (dm_q.size() == 0) && !valid_if_req_i && !valid_dm_req_i &&
           (exp_grant.size() == 0) && (exp_mreq.size() == 0) && (exp_rsp.size() == 0) &&
           (pend.size() == 0);
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #4;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    bit ok = 1'b0;
    while (n < 300) begin
      sample();
      n++;
      if (tb_idle()) begin
        ok = 1'b1;
        break;
      end
    end
    check(nm, 64'(ok), 64'd1);
  endtask

  task automatic expect_req(input logic who, input logic [63:0] a, input logic [63:0] wd,
                            input logic we, input logic [63:0] rd);
    exp_grant.push_back(who);
    exp_mreq.push_back(mreq_t'{a, (who ? wd : 64'h0), (who ? we : 1'b0)});
    exp_rsp.push_back(rsp_t'{who, rd});
    if (who) dm_q.push_back(mreq_t'{a, wd, we});
    else     if_q.push_back(mreq_t'{a, 64'h0, 1'b0});
  endtask

  // Fetch requester: keeps valid high back-to-back while work is queued
  initial begin
    mreq_t m;
    valid_if_req_i = 1'b0;
    addr_if_req_i  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        valid_if_req_i = 1'b0;
        if_hs = 1'b0;
      end else begin
        if (if_hs) begin
          valid_if_req_i = 1'b0;
          if_hs = 1'b0;
        end
        if (!valid_if_req_i && if_q.size() > 0) begin
          m = if_q.pop_front();
          valid_if_req_i = 1'b1;
          addr_if_req_i  = m.addr;
        end
      end
      #4;
      if (valid_if_req_i && ready_if_req_o) if_hs = 1'b1;
    end
  end

  // Data requester
  initial begin
    mreq_t m;
    valid_dm_req_i = 1'b0;
    addr_dm_req_i  = '0;
    wdata_dm_req_i = '0;
    w_en_dm_req_i  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        valid_dm_req_i = 1'b0;
        dm_hs = 1'b0;
      end else begin
        if (dm_hs) begin
          valid_dm_req_i = 1'b0;
          dm_hs = 1'b0;
        end
        if (!valid_dm_req_i && dm_q.size() > 0) begin
          m = dm_q.pop_front();
          valid_dm_req_i = 1'b1;
          addr_dm_req_i  = m.addr;
          wdata_dm_req_i = m.wdata;
          w_en_dm_req_i  = m.wen;
        end
      end
      #4;
      if (valid_dm_req_i && ready_dm_req_o) dm_hs = 1'b1;
    end
  end

  // Memory model: in-order, answers the cycle after acceptance; stores return 0
  initial begin
    pend_t p;
    bit real_rsp;
    ready_mem_i     = 1'b0;
    valid_mem_rsp_i = 1'b0;
    rdata_mem_i     = '0;
    forever begin
      @(negedge clk);
      ready_mem_i = mem_rdy;
      real_rsp = (pend.size() > 0) && (pend[0].due <= cyc) && (rsp_budget > 0);
      if (real_rsp) begin
        valid_mem_rsp_i = 1'b1;
        rdata_mem_i     = pend[0].data;
      end else if (spurious) begin
        valid_mem_rsp_i = 1'b1;
        rdata_mem_i     = 64'hBAD;
      end else begin
        valid_mem_rsp_i = 1'b0;
        rdata_mem_i     = '0;
      end
      #4;
      cyc++;
      if (!rst_n) begin
        pend.delete();
      end else begin
        if (real_rsp && ready_mem_rsp_o) begin
          void'(pend.pop_front());
          rsp_budget--;
        end
        if (valid_mem_o && ready_mem_i) begin
          p.due  = cyc;
          p.data = w_en_mem_o ? 64'h0 : (mem.exists(addr_mem_o) ? mem[addr_mem_o] : 64'h0);
          if (w_en_mem_o) mem[addr_mem_o] = wdata_mem_o;
          pend.push_back(p);
        end
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    bit g_prev = 1'b0;
    logic [63:0] g_addr = '0;
    logic who;
    mreq_t e;
    rsp_t r;
    forever begin
      sample();
      if (!rst_n) begin
        g_prev = 1'b0;
      end else begin
        if (g_prev) begin
          check("req_latency_valid", 64'(valid_mem_o), 64'd1);
          check("req_latency_addr", addr_mem_o, g_addr);
        end
        g_prev = 1'b0;
        if ((valid_if_req_i && ready_if_req_o) || (valid_dm_req_i && ready_dm_req_o)) begin
          check("single_ready", 64'(ready_if_req_o & ready_dm_req_o), 64'd0);
          who = valid_dm_req_i && ready_dm_req_o;
          n_grant++;
          check("grant_expected", 64'(exp_grant.size() != 0), 64'd1);
          if (exp_grant.size() != 0) check("grant_order", 64'(who), 64'(exp_grant.pop_front()));
          g_prev = 1'b1;
          g_addr = who ? addr_dm_req_i : addr_if_req_i;
        end
        if (valid_mem_o && ready_mem_i) begin
          check("mreq_expected", 64'(exp_mreq.size() != 0), 64'd1);
          if (exp_mreq.size() != 0) begin
            e = exp_mreq.pop_front();
            check("mreq_addr", addr_mem_o, e.addr);
            check("mreq_wdata", wdata_mem_o, e.wdata);
            check("mreq_wen", 64'(w_en_mem_o), 64'(e.wen));
          end
        end
        if (valid_if_rsp_o || valid_dm_rsp_o)
          check("single_rsp_valid", 64'(valid_if_rsp_o & valid_dm_rsp_o), 64'd0);
        if ((valid_if_rsp_o && ready_if_rsp_i) || (valid_dm_rsp_o && ready_dm_rsp_i)) begin
          who = valid_dm_rsp_o && ready_dm_rsp_i;
          check("rsp_expected", 64'(exp_rsp.size() != 0), 64'd1);
          if (exp_rsp.size() != 0) begin
            r = exp_rsp.pop_front();
            check("rsp_route", 64'(who), 64'(r.who));
            check("rsp_data", who ? rdata_dm_rsp_o : rdata_if_rsp_o, r.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_values(input string pfx);
    check({pfx, "_valid_mem"}, 64'(valid_mem_o), 64'd0);
    check({pfx, "_addr_mem"}, addr_mem_o, 64'd0);
    check({pfx, "_wdata_mem"}, wdata_mem_o, 64'd0);
    check({pfx, "_w_en_mem"}, 64'(w_en_mem_o), 64'd0);
    check({pfx, "_err"}, 64'(err_o), 64'd0);
  endtask

  initial begin
    int base;
    bit found;
    logic [63:0] a;
    rst_n = 1'b0;
    ready_if_rsp_i = 1'b1;
    ready_dm_rsp_i = 1'b1;
    mem[64'h1000] = 64'h0000_0013;
    mem[64'h1008] = 64'h0010_0093;
    mem[64'h1010] = 64'h0000_0055;

    // Reset state
    repeat (3) sample();
    check_reset_values("rst");
    check("rst_rsp_ready", 64'(ready_mem_rsp_o), 64'd0);
    step();
    rst_n = 1'b1;

    // Single fetch
    step();
    expect_req(1'b0, 64'h1000, 64'h0, 1'b0, 64'h13);
    wait_idle("t1_idle");
    check("t1_count_zero", 64'(ready_mem_rsp_o), 64'd0);

    // Simultaneous dm store and fetch: dm first
    step();
    expect_req(1'b1, 64'h2000, 64'hDEAD, 1'b1, 64'h0);
    expect_req(1'b0, 64'h1008, 64'h0, 1'b0, 64'h0010_0093);
    wait_idle("t2_idle");

    // Memory stall: slot holds, no grants, one transfer on release
    step();
    mem_rdy = 1'b0;
    expect_req(1'b0, 64'h1010, 64'h0, 1'b0, 64'h55);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      sample();
      found = valid_mem_o;
    end
    check("t3_slot_loaded", 64'(found), 64'd1);
    #1;
    expect_req(1'b1, 64'h2000, 64'h0, 1'b0, 64'hDEAD);
    for (int i = 0; i < 5; i++) begin
      sample();
      check("t3_hold_valid", 64'(valid_mem_o), 64'd1);
      check("t3_hold_addr", addr_mem_o, 64'h1010);
      check("t3_hold_wdata", wdata_mem_o, 64'h0);
      check("t3_no_ready_if", 64'(ready_if_req_o), 64'd0);
      check("t3_no_ready_dm", 64'(ready_dm_req_o), 64'd0);
    end
    mem_rdy = 1'b1;
    wait_idle("t3_idle");

    // Outstanding limit: memory silent, 6 fetches -> 4 grants, then 1 more per response
    step();
    rsp_budget = 0;
    base = n_grant;
    for (int i = 0; i < 6; i++) begin
      a = 64'h1100 + 64'(8 * i);
      expect_req(1'b0, a, 64'h0, 1'b0, 64'h0);
    end
    repeat (15) sample();
    check("t4_grants_full", 64'(n_grant - base), 64'd4);
    check("t4_full_no_ready", 64'(ready_if_req_o), 64'd0);
    check("t4_if_waiting", 64'(valid_if_req_i), 64'd1);
    rsp_budget = 1;
    repeat (10) sample();
    check("t4_grants_after_one", 64'(n_grant - base), 64'd5);
    check("t4_full_again", 64'(ready_if_req_o), 64'd0);
    rsp_budget = 1000000;
    wait_idle("t4_idle");

    // dm response back-pressure
    step();
    ready_dm_rsp_i = 1'b0;
    expect_req(1'b1, 64'h2000, 64'h0, 1'b0, 64'hDEAD);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      sample();
      found = valid_dm_rsp_o;
    end
    check("t5_rsp_seen", 64'(found), 64'd1);
    for (int i = 0; i < 3; i++) begin
      if (i != 0) sample();
      check("t5_mem_rsp_blocked", 64'(ready_mem_rsp_o), 64'd0);
      check("t5_head_kept", 64'(valid_dm_rsp_o), 64'd1);
      check("t5_rdata", rdata_dm_rsp_o, 64'hDEAD);
    end
    step();
    ready_dm_rsp_i = 1'b1;
    wait_idle("t5_idle");

    // Spurious response with nothing outstanding
    check("t5_err_clear", 64'(err_o), 64'd0);
    step();
    spurious = 1'b1;
    sample();
    check("t5_spur_not_ready", 64'(ready_mem_rsp_o), 64'd0);
    check("t5_spur_no_if", 64'(valid_if_rsp_o), 64'd0);
    check("t5_spur_no_dm", 64'(valid_dm_rsp_o), 64'd0);
    step();
    spurious = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("t5_err_sticky", 64'(err_o), 64'd1);
    end
    step();
    rst_n = 1'b0;
    #3;
    check_reset_values("t5_rst");
    step();
    rst_n = 1'b1;

    // Both requesting continuously after reset
    step();
`ifdef CPRV_MEM_ARB_RR_EN
    expect_req(1'b1, 64'h2000, 64'h0, 1'b0, 64'hDEAD);
    expect_req(1'b0, 64'h1000, 64'h0, 1'b0, 64'h13);
    expect_req(1'b1, 64'h3000, 64'h0, 1'b0, 64'h0);
    expect_req(1'b0, 64'h1008, 64'h0, 1'b0, 64'h0010_0093);
    expect_req(1'b1, 64'h3008, 64'h0, 1'b0, 64'h0);
    expect_req(1'b0, 64'h1010, 64'h0, 1'b0, 64'h55);
    expect_req(1'b1, 64'h3010, 64'h0, 1'b0, 64'h0);
    expect_req(1'b0, 64'h1018, 64'h0, 1'b0, 64'h0);
`else
    expect_req(1'b1, 64'h2000, 64'h0, 1'b0, 64'hDEAD);
    expect_req(1'b1, 64'h3000, 64'h0, 1'b0, 64'h0);
    expect_req(1'b1, 64'h3008, 64'h0, 1'b0, 64'h0);
    expect_req(1'b1, 64'h3010, 64'h0, 1'b0, 64'h0);
    expect_req(1'b0, 64'h1000, 64'h0, 1'b0, 64'h13);
    expect_req(1'b0, 64'h1008, 64'h0, 1'b0, 64'h0010_0093);
    expect_req(1'b0, 64'h1010, 64'h0, 1'b0, 64'h55);
    expect_req(1'b0, 64'h1018, 64'h0, 1'b0, 64'h0);
`endif
    wait_idle("t6_idle");
    check("t6_err_clear", 64'(err_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
